mc_main_fsm: RTL
================

MC_MAIN_FSM -- requirements
Module: mc_main_fsm

Interface
REQ-001 Parameter TIMEOUT_W, default 4, width of the memory-wait watchdog counter.
REQ-002 Parameter RST_STATE_FETCH, default 1: 1 = leave reset in FETCH; 0 = leave reset in TRAP until trap_clr.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 opcode  in  7  instruction opcode from the instruction register.
REQ-006 mem_ready  in  1  memory completes the current access this cycle.
REQ-007 trap_clr  in  1  one-cycle pulse that releases TRAP.
REQ-008 mem_req  out  1  memory access request.
REQ-009 pc_update, branch, ir_write, reg_write, mem_write, adr_src  out  1 each  datapath strobes/selects.
REQ-010 alu_src_a, alu_src_b, result_src, alu_op  out  2 each  datapath mux selects and ALU class.
REQ-011 imm_src  out  3  immediate format, combinational from opcode: I=000, S=001, B=010, J=011, U=100.
REQ-012 trap  out  1  high while in TRAP; trap_cause  out  2  00 none, 01 illegal opcode, 10 memory timeout.

Function
REQ-013 States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, TRAP.
REQ-014 FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, result_src=10; ir_write=pc_update=mem_ready; go to DECODE on mem_ready, else stay.
REQ-015 DECODE: alu_src_a=01, alu_src_b=01, alu_op=00. Next state by opcode: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR (REQ-030); otherwise -> TRAP with cause 01.
REQ-016 MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Load -> MEMREAD; store -> MEMWRITE (opcode held stable by IR).
REQ-017 MEMREAD: mem_req=1, adr_src=1, result_src=00; on mem_ready -> MEMWB.
REQ-018 MEMWRITE: mem_req=1, mem_write=1, adr_src=1, result_src=00; on mem_ready -> FETCH.
REQ-019 MEMWB: result_src=01, reg_write=1; -> FETCH.
REQ-020 EXECR: alu_src_a=10, alu_src_b=00, alu_op=10; EXECI: alu_src_a=10, alu_src_b=01, alu_op=10; both -> ALUWB.
REQ-021 ALUWB: result_src=00, reg_write=1; -> FETCH.
REQ-022 BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1; -> FETCH.
REQ-023 JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1; -> ALUWB.
REQ-024 All outputs not listed for a state are 0; every non-FETCH state lasts exactly 1 cycle unless waiting on mem_ready.
REQ-025 Watchdog: counter clears on entry to FETCH/MEMREAD/MEMWRITE and increments each waiting cycle; at 2^TIMEOUT_W-1 wait cycles without mem_ready -> TRAP with cause 10. mem_ready in the same cycle as the limit wins.
REQ-026 TRAP: all strobes 0, trap=1, trap_cause held; trap_clr -> FETCH and cause cleared next cycle.
REQ-027 trap_clr outside TRAP is ignored.

Reset
REQ-028 rst_n low: state = FETCH (or TRAP, cause 00, if RST_STATE_FETCH=0), watchdog = 0, trap_cause = 00, immediately and asynchronously.
REQ-029 Reset asserted mid-access drops mem_req in the same cycle; deassertion is synchronised to clk internally.

Configuration
REQ-030 Macro MC_JALR_EN defined: JALR state drives alu_src_a=10, alu_src_b=01, alu_op=00, result_src=00, pc_update=1 and goes to ALUWB. Undefined: opcode 1100111 is illegal (TRAP, cause 01), and JALR is unreachable.

Structure
REQ-031 Shared package holds the state enumeration, opcode constants, imm_src and trap_cause encodings.
REQ-032 One sub-module, mc_wdog, holds the watchdog counter and provides a timeout flag.

Verification
REQ-033 Reset, then lw with mem_ready always 1 -> FETCH,DECODE,MEMADR,MEMREAD,MEMWB (5 cycles); reg_write=1 only in cycle 5.
REQ-034 sw with mem_ready delayed 3 cycles in MEMWRITE -> mem_write high 4 cycles, then FETCH.
REQ-035 opcode 0000000 -> TRAP, trap_cause=01; trap_clr pulse -> FETCH next cycle.
REQ-036 TIMEOUT_W=4 with mem_ready held 0 in FETCH -> TRAP after 15 wait cycles, cause 10; mem_ready on cycle 15 -> DECODE instead.
REQ-037 jal -> pc_update high in FETCH and JAL, reg_write in ALUWB. jalr gives the JALR path with MC_JALR_EN and TRAP (cause 01) without it.
REQ-038 rst_n pulsed low during MEMREAD wait -> mem_req 0 at once, FETCH after release.

Source files
------------

// File: rtl/mc_main_fsm_pkg.sv
// Shared types for the multicycle main controller: state enumeration,
// opcode constants, immediate-format and trap-cause encodings, and the
// per-state control word.
package mc_main_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100
  } imm_t;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00, CAUSE_ILLEGAL = 2'b01, CAUSE_TIMEOUT = 2'b10
  } cause_t;

  // Control word that depends only on the state. FETCH's ir_write and
  // pc_update follow mem_ready and are formed outside this word.
  typedef struct packed {
    logic       mem_req;
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic       branch;
    logic       pc_upd;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_op;
    logic       trap;
  } ctl_t;

  function automatic imm_t imm_of(input logic [6:0] op);
    case (op)
      OP_STORE:          return IMM_S;
      OP_BRANCH:         return IMM_B;
      OP_JAL:            return IMM_J;
      OP_LUI, OP_AUIPC:  return IMM_U;
      default:           return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_main_fsm_if.sv
// Controller <-> datapath/memory bundle. The controller is the master: it
// receives the opcode and memory handshake and drives all strobes/selects.
interface mc_main_fsm_if;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       trap_clr;
  logic       mem_req;
  logic       pc_update;
  logic       branch;
  logic       ir_write;
  logic       reg_write;
  logic       mem_write;
  logic       adr_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [1:0] alu_op;
  logic [2:0] imm_src;
  logic       trap;
  logic [1:0] trap_cause;

  modport master (
    input  opcode, mem_ready, trap_clr,
    output mem_req, pc_update, branch, ir_write, reg_write, mem_write, adr_src,
           alu_src_a, alu_src_b, result_src, alu_op, imm_src, trap, trap_cause
  );

  modport slave (
    output opcode, mem_ready, trap_clr,
    input  mem_req, pc_update, branch, ir_write, reg_write, mem_write, adr_src,
           alu_src_a, alu_src_b, result_src, alu_op, imm_src, trap, trap_cause
  );
endinterface

// File: rtl/mc_main_fsm_wdog.sv
// Memory-wait watchdog. Counts wait cycles of the current access; the
// timeout flag fires during the (2^TIMEOUT_W-1)-th wait cycle so the FSM
// can still prefer a mem_ready arriving in that same cycle.
module mc_wdog #(
  parameter int TIMEOUT_W = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_wait,
  output logic o_timeout
);
  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);

  logic [TIMEOUT_W-1:0] r_cnt;

  // Clear on entry to a waiting state, count every cycle spent waiting.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_cnt <= '0;
    else if (i_clr)  r_cnt <= '0;
    else if (i_wait) r_cnt <= r_cnt + TIMEOUT_W'(1);
  end

  assign o_timeout = i_wait && (r_cnt == LAST);
endmodule

// File: rtl/mc_main_fsm.sv
// Multicycle RISC-V style main controller FSM with memory watchdog and trap
// state. Optional macro MC_JALR_EN enables the JALR path; without it
// opcode 1100111 is treated as illegal.
module mc_main_fsm
  import mc_main_fsm_pkg::*;
#(
  parameter int TIMEOUT_W       = 4,
  parameter int RST_STATE_FETCH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  mc_main_fsm_if.master bus
);
  localparam state_t RST_ST = (RST_STATE_FETCH != 0) ? S_FETCH : S_TRAP;

  function automatic ctl_t ctl_of(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.mem_req = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10; end
      S_DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      S_MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      S_MEMREAD:  begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
      S_MEMWRITE: begin c.mem_req = 1'b1; c.adr_src = 1'b1; c.mem_write = 1'b1; end
      S_MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
      S_EXECR:    begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
      S_EXECI:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
      S_ALUWB:    c.reg_write = 1'b1;
      S_BRANCH:   begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1'b1; end
      S_JAL:      begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_upd = 1'b1; end
`ifdef MC_JALR_EN
      S_JALR:     begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.pc_upd = 1'b1; end
`endif
      S_TRAP:     c.trap = 1'b1;
      default:    ;
    endcase
    return c;
  endfunction

  localparam ctl_t RST_CTL = ctl_of(RST_ST);

  logic [1:0] r_rst_sync;
  logic       w_rst_n;
  state_t     r_state, w_nxt;
  cause_t     r_cause, w_nxt_cause;
  ctl_t       r_ctl, w_act;
  logic       w_wait_st, w_wait, w_clr, w_tmo, w_fetch_rdy;

  // Reset asserts at once, releases two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_wait_st = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);
  assign w_wait    = w_wait_st && !bus.mem_ready;
  assign w_clr     = (w_nxt != r_state) &&
                     ((w_nxt == S_FETCH) || (w_nxt == S_MEMREAD) || (w_nxt == S_MEMWRITE));

  mc_wdog #(.TIMEOUT_W(TIMEOUT_W)) u_wdog (
    .i_clk     (clk),
    .i_rst_n   (w_rst_n),
    .i_clr     (w_clr),
    .i_wait    (w_wait),
    .o_timeout (w_tmo)
  );

  // Next-state and trap-cause selection.
  always_comb begin
    w_nxt       = r_state;
    w_nxt_cause = r_cause;
    case (r_state)
      S_FETCH: begin
        if (bus.mem_ready) w_nxt = S_DECODE;
        else if (w_tmo) begin w_nxt = S_TRAP; w_nxt_cause = CAUSE_TIMEOUT; end
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_LOAD, OP_STORE: w_nxt = S_MEMADR;
          OP_RTYPE:          w_nxt = S_EXECR;
          OP_ITYPE:          w_nxt = S_EXECI;
          OP_BRANCH:         w_nxt = S_BRANCH;
          OP_JAL:            w_nxt = S_JAL;
`ifdef MC_JALR_EN
          OP_JALR:           w_nxt = S_JALR;
`endif
          default: begin w_nxt = S_TRAP; w_nxt_cause = CAUSE_ILLEGAL; end
        endcase
      end
      // IR holds the opcode, so load vs store is still visible here.
      S_MEMADR:  w_nxt = (bus.opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: begin
        if (bus.mem_ready) w_nxt = S_MEMWB;
        else if (w_tmo) begin w_nxt = S_TRAP; w_nxt_cause = CAUSE_TIMEOUT; end
      end
      S_MEMWRITE: begin
        if (bus.mem_ready) w_nxt = S_FETCH;
        else if (w_tmo) begin w_nxt = S_TRAP; w_nxt_cause = CAUSE_TIMEOUT; end
      end
      S_MEMWB, S_ALUWB, S_BRANCH:     w_nxt = S_FETCH;
      S_EXECR, S_EXECI, S_JAL, S_JALR: w_nxt = S_ALUWB;
      S_TRAP: begin
        if (bus.trap_clr) begin w_nxt = S_FETCH; w_nxt_cause = CAUSE_NONE; end
      end
      default: w_nxt = S_FETCH;
    endcase
  end

  // State, cause and the control word of the state being entered.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= RST_ST;
      r_cause <= CAUSE_NONE;
      r_ctl   <= RST_CTL;
    end else begin
      r_state <= w_nxt;
      r_cause <= w_nxt_cause;
      r_ctl   <= ctl_of(w_nxt);
    end
  end

  // Strobes are forced low while reset is held so an access drops at once.
  assign w_act       = w_rst_n ? r_ctl : '0;
  assign w_fetch_rdy = w_rst_n && (r_state == S_FETCH) && bus.mem_ready;

  assign bus.mem_req    = w_act.mem_req;
  assign bus.adr_src    = w_act.adr_src;
  assign bus.mem_write  = w_act.mem_write;
  assign bus.reg_write  = w_act.reg_write;
  assign bus.branch     = w_act.branch;
  assign bus.ir_write   = w_fetch_rdy;
  assign bus.pc_update  = w_act.pc_upd | w_fetch_rdy;
  assign bus.alu_src_a  = w_act.alu_src_a;
  assign bus.alu_src_b  = w_act.alu_src_b;
  assign bus.result_src = w_act.result_src;
  assign bus.alu_op     = w_act.alu_op;
  assign bus.trap       = r_ctl.trap;
  assign bus.trap_cause = r_cause;
  assign bus.imm_src    = imm_of(bus.opcode);
endmodule
